// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: default sizing and FSM state encoding.
package period_meter_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 100_000_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop producing single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [2:0] fill_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= '0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Edges are qualified until s3 holds a real sample, so a high input at
  // reset release is not mistaken for a rising edge against the cleared flops.
  assign rise = fill_q[2] &  s2_q & ~s3_q;
  assign fall = fill_q[2] & ~s2_q &  s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of a slow
// asynchronous signal in clk_in cycles, with a no-edge timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic rise;
  logic fall;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] hi_lat_q,  hi_lat_d;
  logic             hi_seen_q, hi_seen_d;
  logic [WIDTH-1:0] period_q,  period_d;
  logic [WIDTH-1:0] high_q,    high_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q,  locked_d;

  sync_edge u_sync_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    hi_seen_d = hi_seen_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    locked_d  = locked_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_ARMED;
          cnt_d     = ONE;
          hi_seen_d = 1'b0;
        end
      end
      ST_ARMED, ST_MEASURE: begin
        // Rise wins over timeout, so a period of exactly TIMEOUT is still reported.
        if (rise) begin
          state_d   = ST_MEASURE;
          period_d  = cnt_q;
          high_d    = hi_seen_q ? hi_lat_q : '0;
          cnt_d     = ONE;
          hi_seen_d = 1'b0;
          valid_d   = 1'b1;
          locked_d  = 1'b1;
        end else if (cnt_q == TO_CNT) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
          if (fall) begin
            hi_lat_d  = cnt_q;
            hi_seen_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      hi_seen_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      hi_seen_q <= hi_seen_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench: stimulus queues expected results/timeouts, a negedge monitor
// pops and compares whenever the meter raises valid or timeout.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         sig;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         tmo;
  logic         locked;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } res_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] p;
    logic [W-1:0] h;
  } tmo_t;

  res_t res_q[$];
  tmo_t tmo_q[$];
  res_t mon_r;
  tmo_t mon_t;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_rise = 0;

  period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_in     (clk),
    .rst        (rst),
    .sig_in     (sig),
    .period_out (period),
    .high_out   (high),
    .valid      (valid),
    .timeout    (tmo),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid/timeout pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (valid) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got period %0d high %0d at cycle %0d expected no valid",
                 period, high, cyc);
      end else begin
        mon_r = res_q.pop_front();
        chk("valid_period", 32'(period), 32'(mon_r.p));
        chk("valid_high",   32'(high),   32'(mon_r.h));
        chk("valid_locked", 32'(locked), 32'd1);
      end
    end
    if (tmo) begin
      if (tmo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_timeout: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_t = tmo_q.pop_front();
        chk("timeout_cycle",  32'(cyc),    32'(mon_t.cyc));
        chk("timeout_period", 32'(period), 32'(mon_t.p));
        chk("timeout_high",   32'(high),   32'(mon_t.h));
        chk("timeout_locked", 32'(locked), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int p, input int h);
    sig       = 1'b1;
    last_rise = cyc;
    tick(h);
    sig = 1'b0;
    tick(p - h);
  endtask

  task automatic push_res(input int p, input int h, input int n);
    res_t e;
    e.p = W'(p);
    e.h = W'(h);
    repeat (n) res_q.push_back(e);
  endtask

  // Rise reaches the FSM three edges after sig goes high; timeout follows TO edges later.
  task automatic push_tmo(input int rise_cyc, input int p, input int h);
    tmo_t e;
    e.cyc = rise_cyc + 3 + int'(TO);
    e.p   = W'(p);
    e.h   = W'(h);
    tmo_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},   32'(valid),  32'd0);
    chk({tag, "_timeout"}, 32'(tmo),    32'd0);
    chk({tag, "_locked"},  32'(locked), 32'd0);
    chk({tag, "_period"},  32'(period), 32'd0);
    chk({tag, "_high"},    32'(high),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sig = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;

    // Constant high from reset: no edge, so nothing happens.
    tick(80);
    chk("const_high_period", 32'(period), 32'd0);
    chk("const_high_state",  32'(dut.state_q), 32'(ST_IDLE));

    // Single rise then silence: one timeout, no valid.
    sig = 1'b0;
    tick(10);
    sig       = 1'b1;
    last_rise = cyc;
    push_tmo(last_rise, 0, 0);
    tick(5);
    sig = 1'b0;
    tick(70);
    chk("single_rise_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Period 10, high 5.
    push_res(10, 5, 5);
    repeat (6) pulse(10, 5);
    chk("lock_p10", 32'(locked), 32'd1);

    // Change to period 24, high 12; first valid still spans the last 10-cycle period.
    push_res(10, 5, 1);
    push_res(24, 12, 4);
    repeat (5) pulse(24, 12);

    // Rise lands exactly when cnt == TIMEOUT: reported, no timeout.
    push_res(24, 12, 1);
    push_res(50, 20, 2);
    repeat (3) pulse(50, 20);

    // Stuck low after lock: timeout 50 counts after the last rise, results held.
    push_tmo(last_rise, 50, 20);
    tick(10);
    chk("after_timeout_locked", 32'(locked), 32'd0);
    chk("after_timeout_state",  32'(dut.state_q), 32'(ST_IDLE));
    chk("after_timeout_period", 32'(period), 32'd50);

    // Reset mid-period, then two fresh rises needed for the first valid.
    push_res(10, 5, 2);
    repeat (3) pulse(10, 5);
    rst = 1'b1;
    tick(1);
    check_zero("mid_reset");
    rst = 1'b0;
    tick(5);
    push_res(10, 5, 2);
    repeat (3) pulse(10, 5);
    chk("relock_p10", 32'(locked), 32'd1);

    tick(5);
    chk("valid_queue_drained",   32'(res_q.size()), 32'd0);
    chk("timeout_queue_drained", 32'(tmo_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the counter and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 100_000_000, giving the cycles without a rising edge before the measurement is abandoned; TIMEOUT < 2^WIDTH.
REQ-003 SHALL have port clk_in, input, 1 bit: the system clock, and the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sig_in, input, 1 bit: the slow clock or divided signal under measurement, asynchronous to clk_in.
REQ-006 SHALL have port period_out, output, WIDTH bits: the last measured rising-to-rising period, in clk_in cycles.
REQ-007 SHALL have port high_out, output, WIDTH bits: the last measured high time (rising-to-falling), in clk_in cycles.
REQ-008 SHALL have port valid, output, 1 bit: a one-cycle pulse when period_out and high_out update.
REQ-009 SHALL have port timeout, output, 1 bit: a one-cycle pulse when TIMEOUT expires with no rising edge.
REQ-010 SHALL have port locked, output, 1 bit: high while in MEASURE after at least one valid result.

Function
REQ-011 SHALL pass sig_in through a two-flop synchronizer and one history flop; rise = s2 & ~s3, fall = ~s2 & s3; edge pulses lag sig_in by 3 cycles.
REQ-012 SHALL implement the FSM IDLE -> ARMED on rise (cnt <= 1); ARMED -> MEASURE on the next rise; MEASURE -> MEASURE on each rise; ARMED or MEASURE -> IDLE on timeout.
REQ-013 SHALL, in ARMED and MEASURE, increment cnt by 1 every cycle without a rise.
REQ-014 SHALL, on fall in ARMED or MEASURE, capture hi_lat <= cnt.
REQ-015 SHALL, on rise in ARMED or MEASURE, set period_out <= cnt, high_out <= hi_lat, cnt <= 1, and pulse valid the following cycle with the new values visible; the result equals the cycle distance between the two rise pulses.
REQ-016 SHALL, if no fall occurred since the previous rise, load high_out with 0.
REQ-017 SHALL, when cnt == TIMEOUT in ARMED or MEASURE with no rise that cycle, pulse timeout, enter IDLE, clear locked, and hold period_out and high_out unchanged.
REQ-018 SHALL give rise priority over timeout when both occur in the same cycle.
REQ-019 SHALL ignore rise and fall in IDLE, except that a rise starts ARMED.
REQ-020 SHALL never let cnt wrap, guaranteed by REQ-002 and REQ-017.
REQ-021 SHALL set locked on the first valid and clear it on timeout or reset.

Reset
REQ-022 SHALL, while rst = 1 at a clk_in edge, set the state to IDLE and clear cnt, hi_lat, period_out, high_out, valid, timeout, locked and the synchronizer flops to 0.
REQ-023 SHALL, on reset mid-measurement, discard the partial count; the first valid after release requires two fresh rising edges.

Structure
REQ-024 SHALL place the FSM state encoding (IDLE, ARMED, MEASURE) and the default WIDTH/TIMEOUT constants in the shared package period_meter_pkg.
REQ-025 SHALL implement the synchronizer and edge detector (REQ-011) as sub-module sync_edge, with ports clk_in, rst, d, rise, fall.

Verification
REQ-026 SHALL cover: sig_in period 10 clk_in cycles, high 5 -> after the second rise, valid with period_out = 10 and high_out = 5, repeating every 10 cycles; locked = 1.
REQ-027 SHALL cover: period changed from 10 to 24 (high 12) mid-run -> the first valid after the change reports 10 or 24, all later valids report period_out = 24 and high_out = 12.
REQ-028 SHALL cover: TIMEOUT = 50 and sig_in stuck low after lock -> timeout pulse exactly 50 counts after the last rise; state IDLE, locked = 0, period_out holds its last value.
REQ-029 SHALL cover: rst asserted for 1 cycle mid-period -> all outputs 0 the next cycle; no valid until two rises after release.
REQ-030 SHALL cover: sig_in constant high from reset -> no valid and no timeout (stays in IDLE); a single rise then silence with TIMEOUT = 50 -> one timeout pulse and no valid.
REQ-031 SHALL cover: rise arriving on the same cycle cnt == TIMEOUT -> valid with period_out = TIMEOUT and no timeout pulse.
